// File: rtl/event_merge_arbiter.sv
// -----------------------------------------------------------------------------
// event_merge_arbiter
//
// Order-preserving merge of NUM_SRC raster-ordered event streams into the
// single event input of the event scheduler. Each source feeds a one-entry
// head register. A decision is made only once every source is resolved,
// meaning it holds either an event or its end-of-frame marker. The smallest
// held address is then issued. Equal addresses are shared round-robin. An
// issued address that goes backwards within a frame sets a sticky error
// flag. A one-cycle frame_done pulse follows the last event of a frame.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   src_valid/eof     per-source handshake; eof transfers carry no event
//   src_addr/value    packed per-source event, source i at [i*W +: W]
//   src_ready         per-source ready (head empty, not in frame end)
//   sched_ready       scheduler ready_for_new_event
//   out_event_*       registered event towards the scheduler
//   frame_done        one-cycle pulse after the frame's last event
//   order_error       sticky out-of-order flag, cleared only by rst
// -----------------------------------------------------------------------------
module event_merge_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC-1:0]            src_eof,
  input  logic [NUM_SRC*ADDR_WIDTH-1:0] src_addr,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_value,
  output logic [NUM_SRC-1:0]            src_ready,
  input  logic                          sched_ready,
  output logic [ADDR_WIDTH-1:0]         out_event_addr,
  output logic [DATA_WIDTH-1:0]         out_event_value,
  output logic                          out_event_valid,
  output logic                          frame_done,
  output logic                          order_error
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [0:0] {
    S_RUN = 1'b0,
    S_END = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_SRC-1:0]     hold_vld_q, hold_vld_d;
  logic [NUM_SRC-1:0]     hold_eof_q, hold_eof_d;
  logic [ADDR_WIDTH-1:0]  hold_addr_q [NUM_SRC];
  logic [ADDR_WIDTH-1:0]  hold_addr_d [NUM_SRC];
  logic [DATA_WIDTH-1:0]  hold_val_q  [NUM_SRC];
  logic [DATA_WIDTH-1:0]  hold_val_d  [NUM_SRC];
  logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [ADDR_WIDTH-1:0]  last_addr_q, last_addr_d;
  logic                   last_addr_vld_q, last_addr_vld_d;
  logic                   out_valid_q, out_valid_d;
  logic [ADDR_WIDTH-1:0]  out_addr_q, out_addr_d;
  logic [DATA_WIDTH-1:0]  out_val_q, out_val_d;
  logic                   frame_done_q, frame_done_d;
  logic                   order_error_q, order_error_d;

  // Selection results
  logic                   all_resolved;
  logic [ADDR_WIDTH-1:0]  min_addr;
  logic [NUM_SRC-1:0]     tie_mask;
  logic                   multi_tie;
  logic                   found;
  logic [PTR_W-1:0]       win_idx;
  logic [PTR_W-1:0]       idx_w;
  int                     idx;
  logic [PTR_W-1:0]       rr_next;
  logic                   consume;
  logic                   load;

  assign src_ready = ~hold_vld_q & ~hold_eof_q & {NUM_SRC{state_q == S_RUN}};

  // Minimum search over held events and round-robin pick among equal minima
  always_comb begin
    all_resolved = &(hold_vld_q | hold_eof_q);
    min_addr     = {ADDR_WIDTH{1'b1}};
    tie_mask     = {NUM_SRC{1'b0}};
    found        = 1'b0;
    win_idx      = {PTR_W{1'b0}};
    idx          = 0;
    idx_w        = {PTR_W{1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      min_addr = (hold_vld_q[i] && (hold_addr_q[i] < min_addr)) ? hold_addr_q[i] : min_addr;
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      tie_mask[i] = hold_vld_q[i] && (hold_addr_q[i] == min_addr);
    end
    multi_tie = ($countones(tie_mask) > 1);
    // First minimum-holding candidate at or after rr_ptr, wrapping modulo NUM_SRC
    for (int k = 0; k < NUM_SRC; k++) begin
      idx   = int'(rr_ptr_q) + k;
      idx   = (idx >= NUM_SRC) ? (idx - NUM_SRC) : idx;
      idx_w = PTR_W'(idx);
      if (!found && tie_mask[idx_w]) begin
        found   = 1'b1;
        win_idx = idx_w;
      end else begin
        found   = found;
      end
    end
    rr_next = (win_idx == PTR_W'(NUM_SRC - 1)) ? {PTR_W{1'b0}} : (win_idx + PTR_W'(1));
  end

  // Next-state: head capture, output load/consume, order check, frame FSM
  always_comb begin
    state_d         = state_q;
    hold_vld_d      = hold_vld_q;
    hold_eof_d      = hold_eof_q;
    hold_addr_d     = hold_addr_q;
    hold_val_d      = hold_val_q;
    rr_ptr_d        = rr_ptr_q;
    last_addr_d     = last_addr_q;
    last_addr_vld_d = last_addr_vld_q;
    out_valid_d     = out_valid_q;
    out_addr_d      = out_addr_q;
    out_val_d       = out_val_q;
    frame_done_d    = 1'b0;
    order_error_d   = order_error_q;

    consume = out_valid_q & sched_ready;
    // Output slot is free when empty or being drained in this same cycle
    load    = (state_q == S_RUN) & all_resolved & (|hold_vld_q) & (~out_valid_q | sched_ready);

    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_valid[i] && src_ready[i]) begin
        if (src_eof[i]) begin
          hold_eof_d[i] = 1'b1;
        end else begin
          hold_vld_d[i]  = 1'b1;
          hold_addr_d[i] = src_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
          hold_val_d[i]  = src_value[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end else begin
        hold_vld_d[i] = hold_vld_d[i];
      end
    end

    if (load) begin
      hold_vld_d[win_idx] = 1'b0;
      out_valid_d         = 1'b1;
      out_addr_d          = hold_addr_q[win_idx];
      out_val_d           = hold_val_q[win_idx];
      last_addr_d         = hold_addr_q[win_idx];
      last_addr_vld_d     = 1'b1;
      if (last_addr_vld_q && (hold_addr_q[win_idx] < last_addr_q)) begin
        order_error_d = 1'b1;
      end else begin
        order_error_d = order_error_q;
      end
      if (multi_tie) begin
        rr_ptr_d = rr_next;
      end else begin
        rr_ptr_d = rr_ptr_q;
      end
    end else if (consume) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    case (state_q)
      S_RUN: begin
        if ((&hold_eof_q) && !(|hold_vld_q) && (!out_valid_q || consume)) begin
          state_d      = S_END;
          frame_done_d = 1'b1;
        end else begin
          state_d      = S_RUN;
        end
      end
      S_END: begin
        hold_eof_d      = {NUM_SRC{1'b0}};
        last_addr_vld_d = 1'b0;
        state_d         = S_RUN;
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_RUN;
      hold_vld_q      <= {NUM_SRC{1'b0}};
      hold_eof_q      <= {NUM_SRC{1'b0}};
      for (int i = 0; i < NUM_SRC; i++) begin
        hold_addr_q[i] <= {ADDR_WIDTH{1'b0}};
        hold_val_q[i]  <= {DATA_WIDTH{1'b0}};
      end
      rr_ptr_q        <= {PTR_W{1'b0}};
      last_addr_q     <= {ADDR_WIDTH{1'b0}};
      last_addr_vld_q <= 1'b0;
      out_valid_q     <= 1'b0;
      out_addr_q      <= {ADDR_WIDTH{1'b0}};
      out_val_q       <= {DATA_WIDTH{1'b0}};
      frame_done_q    <= 1'b0;
      order_error_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      hold_vld_q      <= hold_vld_d;
      hold_eof_q      <= hold_eof_d;
      hold_addr_q     <= hold_addr_d;
      hold_val_q      <= hold_val_d;
      rr_ptr_q        <= rr_ptr_d;
      last_addr_q     <= last_addr_d;
      last_addr_vld_q <= last_addr_vld_d;
      out_valid_q     <= out_valid_d;
      out_addr_q      <= out_addr_d;
      out_val_q       <= out_val_d;
      frame_done_q    <= frame_done_d;
      order_error_q   <= order_error_d;
    end
  end

  assign out_event_valid = out_valid_q;
  assign out_event_addr  = out_addr_q;
  assign out_event_value = out_val_q;
  assign frame_done      = frame_done_q;
  assign order_error     = order_error_q;

endmodule
